// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit {rw, addr[6:0], data[7:0]} frame per accepted start, MSB first.
// Latency: busy for CS_SETUP + (16+TRAIL)*2*DIV + CS_HOLD + CS_IDLE cycles after accept; done pulses in the first idle cycle.
// Backpressure: start is only sampled while busy=0; requests made while busy are dropped, never queued.
module spi_controller #(
    parameter int DIV      = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4,
    parameter int TRAIL    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_TRAIL,
        S_HOLD,
        S_GAP
    } state_t;

    // Counters are loaded with N-1 and count down to zero, giving exactly N cycles per phase.
    localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_M1  = 8'(CS_IDLE - 1);
    localparam logic [1:0] TRAIL_M1 = 2'(TRAIL - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_cnt;
    logic [1:0]  trail_cnt;
    logic [15:0] sr;
    logic [7:0]  rx;
    logic        is_rd;

    // Frame sequencer: every output is a register updated only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            trail_cnt <= '0;
            sr        <= '0;
            rx        <= '0;
            is_rd     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr      <= {rw, addr, wdata};
                        copi    <= rw;
                        is_rd   <= ~rw;
                        ncs     <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= SETUP_M1;
                        bit_cnt <= 4'd15;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == 8'd0) begin
                        sclk  <= 1'b1;
                        cnt   <= DIV_M1;
                        state <= S_SHIFT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (sclk) begin
                        // Falling edge: present the next bit; zeros shift in behind bit 0.
                        sclk <= 1'b0;
                        cnt  <= DIV_M1;
                        sr   <= {sr[14:0], 1'b0};
                        copi <= sr[14];
                    end else if (bit_cnt != 4'd0) begin
                        // Rising edge of bit (bit_cnt-1); capture cipo for data bits 7..0.
                        bit_cnt <= bit_cnt - 4'd1;
                        sclk    <= 1'b1;
                        cnt     <= DIV_M1;
                        if (is_rd && bit_cnt <= 4'd8) begin
                            rx <= {rx[6:0], cipo};
                        end
                    end else if (TRAIL > 0) begin
                        state     <= S_TRAIL;
                        trail_cnt <= TRAIL_M1;
                        sclk      <= 1'b1;
                        cnt       <= DIV_M1;
                    end else begin
                        state <= S_HOLD;
                        cnt   <= HOLD_M1;
                    end
                end
                S_TRAIL: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (sclk) begin
                        sclk <= 1'b0;
                        cnt  <= DIV_M1;
                    end else if (trail_cnt != 2'd0) begin
                        trail_cnt <= trail_cnt - 2'd1;
                        sclk      <= 1'b1;
                        cnt       <= DIV_M1;
                    end else begin
                        state <= S_HOLD;
                        cnt   <= HOLD_M1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 8'd0) begin
                        ncs   <= 1'b1;
                        cnt   <= IDLE_M1;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 8'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                        if (is_rd) begin
                            rdata <= rx;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
